// File: rtl/chunked_adder_unit.sv
// Multi-cycle WIDTH-bit add/subtract unit processing CHUNK bits per clock, LSB slice first.
// Optional macro ADDER_SATURATE_EN clamps an overflowing result to the signed extreme.
module chunked_adder_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q, sum_final;
  logic             cout_q, ovf_q;
  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   slice_sum;
  logic             accept, last_slice, ovf_raw;

  // New work is only taken when not mid-operation; start during RUN is dropped.
  always_comb begin
    accept     = start && (state_q != StRun);
    last_slice = (idx_q == LAST_IDX);
  end

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    acc_d   = acc_q;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = b_q[i*CHUNK +: CHUNK];
      end
    end
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (idx_q == IDX_W'(i)) begin
        acc_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
      end
    end
  end

  // Same-sign operands giving an opposite-sign result is equivalent to cin(MSB) ^ cout(MSB).
  always_comb begin
    ovf_raw = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDER_SATURATE_EN
    if (ovf_raw) begin
      sum_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_final = acc_d;
    end
`else
    sum_final = acc_d;
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub | cin;
      idx_q   <= '0;
    end else if (state_q == StRun) begin
      acc_q   <= acc_d;
      carry_q <= slice_sum[CHUNK];
      idx_q   <= idx_q + IDX_W'(1);
      // Visible outputs change only once the whole result is known.
      if (last_slice) begin
        sum_q  <= sum_final;
        cout_q <= slice_sum[CHUNK];
        ovf_q  <= ovf_raw;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder_unit.sv
// Self-checking bench for chunked_adder_unit (WIDTH=16, CHUNK=4): vector table plus
// scoreboard, with hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_chunked_adder_unit;

  localparam int NCHUNK = 4;
`ifdef ADDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clock, resetn, start, sub, cin;
  logic [15:0] a, b, sum;
  logic        busy, done, cout, ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [15:0] last_sum = '0;
  vec_t vecs[9];

  chunked_adder_unit #(.WIDTH(16), .CHUNK(4)) dut (
    .clock (clock),
    .resetn(resetn),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (resetn && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e.s));
        chk("sb_cout", 32'(cout), 32'(e.c));
        chk("sb_ovf", 32'(ovf), 32'(e.o));
      end
    end
  end

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clock);
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; start = 1'b1;
    sb_q.push_back('{v.s, v.c, v.o});
    @(negedge clock);
    start = 1'b0;
    a = ~v.a; b = ~v.b; sub = ~v.sub; cin = ~v.cin;
    for (int k = 0; k < NCHUNK; k++) begin
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      if (k == 1) chk("hold_sum", 32'(sum), 32'(last_sum));
      @(negedge clock);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    last_sum = v.s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 1'b1, 16'hBCDF, 1'b0, 1'b0};

    resetn = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // start during RUN is ignored and operand changes have no effect
    @(negedge clock);
    a = vecs[0].a; b = vecs[0].b; sub = vecs[0].sub; cin = vecs[0].cin; start = 1'b1;
    sb_q.push_back('{vecs[0].s, vecs[0].c, vecs[0].o});
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(10);
    @(negedge clock);
    chk("ignored_start_busy", 32'(busy), 32'd0);
    chk("ignored_start_done", 32'(done), 32'd0);
    last_sum = vecs[0].s;

    // start held high through DONE: second op starts with no IDLE cycle
    @(negedge clock);
    a = vecs[8].a; b = vecs[8].b; sub = vecs[8].sub; cin = vecs[8].cin; start = 1'b1;
    sb_q.push_back('{vecs[8].s, vecs[8].c, vecs[8].o});
    @(negedge clock);
    a = vecs[5].a; b = vecs[5].b; sub = vecs[5].sub; cin = vecs[5].cin;
    sb_q.push_back('{vecs[5].s, vecs[5].c, vecs[5].o});
    wait_done(10);
    @(negedge clock);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_first_sum", 32'(sum), 32'(vecs[8].s));
    start = 1'b0;
    wait_done(10);
    last_sum = vecs[5].s;

    // asynchronous reset in the middle of RUN
    @(negedge clock);
    a = vecs[0].a; b = vecs[0].b; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    last_sum = '0;
    @(negedge clock);
    resetn = 1'b1;
    run_op(vecs[2]);
    run_op(vecs[3]);

    @(negedge clock);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
